// File: rtl/seg_display_decoder.sv
// seg_display_decoder: reconstructs the 0-9999 count shown on four active-low 7-segment digits.
// Define SEG_STEP_CHECK_EN to generate the dir_up/dir_down/step_err classification pulses.
module seg_display_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  Disp_un,
    input  logic [6:0]  Disp_dec,
    input  logic [6:0]  Disp_cent,
    input  logic [6:0]  Disp_mil,
    output logic [13:0] value,
    output logic        valid,
    output logic        changed,
    output logic        dir_up,
    output logic        dir_down,
    output logic        step_err,
    output logic        seg_err
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] SMAX = CW'(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    state_t      r_state;
    logic [27:0] r_snap;
    logic [CW-1:0] r_stab;
    logic        r_done;
    logic [3:0]  r_dig [0:3];
    logic        r_ok;
    logic [13:0] r_acc;
    logic [1:0]  r_idx;
    logic [27:0] w_in;
    logic [4:0]  w_dec [0:3];
    logic        w_ok;

    // returns {legal, digit}
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h40:   decode = 5'h10;
            7'h79:   decode = 5'h11;
            7'h24:   decode = 5'h12;
            7'h30:   decode = 5'h13;
            7'h19:   decode = 5'h14;
            7'h12:   decode = 5'h15;
            7'h02:   decode = 5'h16;
            7'h78:   decode = 5'h17;
            7'h00:   decode = 5'h18;
            7'h10:   decode = 5'h19;
            default: decode = 5'h00;
        endcase
    endfunction

    assign w_in = {Disp_mil, Disp_cent, Disp_dec, Disp_un};

    always_comb begin
        for (int k = 0; k < 4; k++) w_dec[k] = decode(r_snap[7*k +: 7]);
    end

    assign w_ok = w_dec[0][4] & w_dec[1][4] & w_dec[2][4] & w_dec[3][4];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_snap  <= {4{7'h7F}};
            r_stab  <= '0;
            r_done  <= 1'b0;
            for (int k = 0; k < 4; k++) r_dig[k] <= 4'd0;
            r_ok    <= 1'b0;
            r_acc   <= 14'd0;
            r_idx   <= 2'd0;
            value   <= 14'd0;
            valid   <= 1'b0;
            changed <= 1'b0;
            seg_err <= 1'b0;
        end else begin
            changed <= 1'b0;
            case (r_state)
                IDLE: if (r_stab == SMAX && !r_done) begin
                    r_state <= CONV;
                    for (int k = 0; k < 4; k++) r_dig[k] <= w_dec[k][3:0];
                    r_ok   <= w_ok;
                    r_acc  <= 14'd0;
                    r_idx  <= 2'd3;
                    r_done <= 1'b1;
                end
                CONV: begin
                    r_acc <= r_acc * 14'd10 + {10'd0, r_dig[r_idx]};
                    r_idx <= r_idx - 2'd1;
                    if (r_idx == 2'd0) r_state <= UPDATE;
                end
                default: begin
                    r_state <= IDLE;
                    if (!r_ok) begin
                        seg_err <= 1'b1;
                        valid   <= 1'b0;
                    end else begin
                        seg_err <= 1'b0;
                        valid   <= 1'b1;
                        value   <= r_acc;
                        changed <= !valid || r_acc != value;
                    end
                end
            endcase
            // a fresh snapshot overrides a start taken on the same edge
            if (w_in != r_snap) begin
                r_snap <= w_in;
                r_stab <= '0;
                r_done <= 1'b0;
            end else if (r_stab != SMAX) begin
                r_stab <= r_stab + 1'b1;
            end
        end
    end

`ifdef SEG_STEP_CHECK_EN
    logic w_up, w_down;

    assign w_up   = (r_acc == value + 14'd1) || (value == 14'd9999 && r_acc == 14'd0);
    assign w_down = (r_acc + 14'd1 == value) || (value == 14'd0 && r_acc == 14'd9999);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_up   <= 1'b0;
            dir_down <= 1'b0;
            step_err <= 1'b0;
        end else begin
            dir_up   <= 1'b0;
            dir_down <= 1'b0;
            step_err <= 1'b0;
            if (r_state == UPDATE && r_ok && valid && r_acc != value) begin
                dir_up   <= w_up;
                dir_down <= w_down;
                step_err <= !w_up && !w_down;
            end
        end
    end
`else
    assign dir_up   = 1'b0;
    assign dir_down = 1'b0;
    assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_seg_display_decoder.sv
// tb_seg_display_decoder: directed and random display patterns checked every cycle against a timeline model.
module tb_seg_display_decoder;
    localparam int S = 4;
`ifdef SEG_STEP_CHECK_EN
    localparam bit STEP = 1'b1;
`else
    localparam bit STEP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  Disp_un = 7'h7F, Disp_dec = 7'h7F, Disp_cent = 7'h7F, Disp_mil = 7'h7F;
    logic [13:0] value;
    logic        valid, changed, dir_up, dir_down, step_err, seg_err;

    int n_checks = 0;
    int n_err = 0;

    logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seg_display_decoder #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst),
        .Disp_un(Disp_un), .Disp_dec(Disp_dec), .Disp_cent(Disp_cent), .Disp_mil(Disp_mil),
        .value(value), .valid(valid), .changed(changed),
        .dir_up(dir_up), .dir_down(dir_down), .step_err(step_err), .seg_err(seg_err)
    );

    always #5 clk = ~clk;

    function automatic int snap_num(input logic [27:0] s);
        int d [4];
        for (int k = 0; k < 4; k++) begin
            d[k] = -1;
            for (int j = 0; j < 10; j++) if (s[7*k +: 7] == pat[j]) d[k] = j;
            if (d[k] < 0) return -1;
        end
        return 1000*d[3] + 100*d[2] + 10*d[1] + d[0];
    endfunction

    // model: a stable snapshot starts a job; its result lands 5 edges later
    logic [27:0] m_snap;
    int m_age, m_cnt, m_num, m_value, diff;
    bit m_done, m_valid, m_chg, m_up, m_dn, m_st, m_seg;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_snap = {4{7'h7F}}; m_age = 0; m_done = 0; m_cnt = 0; m_num = 0;
            m_value = 0; m_valid = 0; m_chg = 0; m_up = 0; m_dn = 0; m_st = 0; m_seg = 0;
        end else begin
            m_chg = 0; m_up = 0; m_dn = 0; m_st = 0;
            if (m_cnt == 1) begin
                if (m_num < 0) begin
                    m_seg = 1; m_valid = 0;
                end else begin
                    if (!m_valid || m_num != m_value) m_chg = 1;
                    if (STEP && m_valid && m_num != m_value) begin
                        diff = (m_num - m_value + 10000) % 10000;
                        m_up = (diff == 1);
                        m_dn = (diff == 9999);
                        m_st = !(m_up || m_dn);
                    end
                    m_value = m_num; m_valid = 1; m_seg = 0;
                end
            end
            if (m_cnt > 0) m_cnt--;
            else if (m_age == S && !m_done) begin
                m_num = snap_num(m_snap); m_cnt = 5; m_done = 1;
            end
            if ({Disp_mil, Disp_cent, Disp_dec, Disp_un} != m_snap) begin
                m_snap = {Disp_mil, Disp_cent, Disp_dec, Disp_un}; m_age = 0; m_done = 0;
            end else if (m_age < S) m_age++;
        end
    end

    initial forever begin
        @(negedge clk);
        n_checks++;
        if ({value, valid, changed, dir_up, dir_down, step_err, seg_err} !=
            {14'(m_value), m_valid, m_chg, m_up, m_dn, m_st, m_seg}) begin
            n_err++;
            $display("FAIL outputs t=%0t: got value=%0d v=%b chg=%b up=%b dn=%b st=%b seg=%b expected value=%0d v=%b chg=%b up=%b dn=%b st=%b seg=%b",
                     $time, value, valid, changed, dir_up, dir_down, step_err, seg_err,
                     m_value, m_valid, m_chg, m_up, m_dn, m_st, m_seg);
        end
    end

    bit s_chg, s_up, s_dn, s_st;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_num(input int n);
        Disp_mil  = pat[(n / 1000) % 10];
        Disp_cent = pat[(n / 100) % 10];
        Disp_dec  = pat[(n / 10) % 10];
        Disp_un   = pat[n % 10];
    endtask

    task automatic clr();
        s_chg = 0; s_up = 0; s_dn = 0; s_st = 0;
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            @(negedge clk);
            s_chg |= changed; s_up |= dir_up; s_dn |= dir_down; s_st |= step_err;
        end
    endtask

    task automatic show(input int n);
        set_num(n); clr(); hold(14);
    endtask

    int last, r, n;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_value", value, 0);
        check("reset_valid", valid, 0);
        check("reset_seg_err", seg_err, 0);
        set_num(42);
        rst = 1'b1;
        clr(); hold(20);
        check("first_value", value, 42);
        check("first_valid", valid, 1);
        check("first_changed", s_chg, 1);
        check("first_no_dir", s_up + s_dn + s_st, 0);
        show(43);
        check("up_value", value, 43);
        check("up_dir", s_up, STEP);
        show(42);
        check("down_dir", s_dn, STEP);
        show(9999);
        show(0);
        check("wrap_up_value", value, 0);
        check("wrap_up_dir", s_up, STEP);
        show(9999);
        check("wrap_down_value", value, 9999);
        check("wrap_down_dir", s_dn, STEP);
        show(42);
        show(50);
        check("jump_value", value, 50);
        check("jump_step_err", s_st, STEP);
        show(42);
        clr();
        Disp_un = pat[3]; hold(3);
        Disp_un = pat[2]; hold(14);
        check("glitch_no_change", s_chg, 0);
        check("glitch_value", value, 42);
        clr();
        Disp_un = 7'h7F; hold(14);
        check("blank_seg_err", seg_err, 1);
        check("blank_valid", valid, 0);
        check("blank_value", value, 42);
        check("blank_no_change", s_chg, 0);
        clr();
        Disp_un = pat[2]; hold(14);
        check("recover_seg_err", seg_err, 0);
        check("recover_valid", valid, 1);
        check("recover_changed", s_chg, 1);
        check("recover_no_dir", s_up + s_dn + s_st, 0);
        set_num(43); hold(7);
        #2 rst = 1'b0;
        #1;
        check("midconv_value", value, 0);
        check("midconv_valid", valid, 0);
        hold(2);
        rst = 1'b1;
        clr(); hold(14);
        check("after_rst_value", value, 43);
        check("after_rst_changed", s_chg, 1);
        last = 43;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            n = last;
            if (r < 3) n = (last + 1) % 10000;
            else if (r < 6) n = (last + 9999) % 10000;
            else if (r == 6) n = $urandom_range(0, 9999);
            set_num(n);
            if (r == 7) Disp_dec = 7'($urandom_range(0, 127));
            last = n;
            hold($urandom_range(1, 14));
        end
        hold(14);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
